// File: rtl/seg7_pkg.sv
// Shared types and active-low segment patterns for the seven-segment scan driver.
package seg7_pkg;

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } slot_t;

    typedef enum logic [3:0] {
        G_0     = 4'd0,
        G_1     = 4'd1,
        G_2     = 4'd2,
        G_3     = 4'd3,
        G_4     = 4'd4,
        G_5     = 4'd5,
        G_6     = 4'd6,
        G_7     = 4'd7,
        G_8     = 4'd8,
        G_9     = 4'd9,
        G_U     = 4'd10,
        G_D     = 4'd11,
        G_BLANK = 4'd15
    } glyph_t;

    // Bit order {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_U     = 7'b1000001;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_OFF = 4'b1111;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle: count/direction/enable in, anode/segment drive out.
interface seg7_scan_driver_if;
    logic [3:0] value_in;
    logic       count_up;
    logic       enable;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (output value_in, count_up, enable, input an, seg, dp);
    modport slave  (input value_in, count_up, enable, output an, seg, dp);
endinterface

// File: rtl/seg7_encode.sv
// Combinational glyph code to active-low segment pattern; unknown codes go blank.
module seg7_encode
    import seg7_pkg::*;
(
    input  glyph_t     glyph,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (glyph)
            G_0:     seg = SEG_0;
            G_1:     seg = SEG_1;
            G_2:     seg = SEG_2;
            G_3:     seg = SEG_3;
            G_4:     seg = SEG_4;
            G_5:     seg = SEG_5;
            G_6:     seg = SEG_6;
            G_7:     seg = SEG_7;
            G_8:     seg = SEG_8;
            G_9:     seg = SEG_9;
            G_U:     seg = SEG_U;
            G_D:     seg = SEG_D;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Scans a 0..15 count (decimal, digits 1:0) and a direction glyph (digit 3) onto a
// 4-digit common-anode display, with a per-frame snapshot and anti-ghost blanking.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGIT_TICKS = 100000,
    parameter int BLANK_TICKS = 2,
    parameter bit LZ_BLANK    = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    seg7_scan_driver_if.slave bus
);

    localparam int TW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(DIGIT_TICKS - 1);
    localparam logic [TW-1:0] BLANK_T   = TW'(BLANK_TICKS);

    logic [4:0]    sync1, sync2, sync3;
    logic          stable;
    logic [TW-1:0] tick;
    logic          wrap;
    slot_t         slot, slot_nxt;
    logic [3:0]    snap_val;
    logic          snap_up;
    logic          first;
    logic          load;
    logic          tens;
    logic [3:0]    units;
    glyph_t        glyph;
    logic [3:0]    an_nxt;
    logic [6:0]    seg_nxt;

    // Upstream runs on a divided clock; the third stage only detects settling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= {bus.value_in, bus.count_up};
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign stable = (sync2 == sync3);

    assign wrap = (tick == TICK_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) tick <= '0;
        else       tick <= wrap ? '0 : tick + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) slot <= DIG0;
        else       slot <= slot_nxt;
    end

    always_comb begin
        slot_nxt = slot;
        if (wrap) begin
            case (slot)
                DIG0:    slot_nxt = DIG1;
                DIG1:    slot_nxt = DIG2;
                DIG2:    slot_nxt = DIG3;
                default: slot_nxt = DIG0;
            endcase
        end
    end

    // Snapshot only at frame boundaries so a frame never mixes two values.
    assign load = stable && (first || (wrap && slot == DIG3));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_val <= '0;
            snap_up  <= 1'b1;
            first    <= 1'b1;
        end else if (load) begin
            {snap_val, snap_up} <= sync2;
            first               <= 1'b0;
        end
    end

    assign tens  = (snap_val >= 4'd10);
    assign units = tens ? snap_val - 4'd10 : snap_val;

    always_comb begin
        glyph  = G_BLANK;
        an_nxt = AN_OFF;
        case (slot)
            DIG0: begin
                glyph  = glyph_t'(units);
                an_nxt = 4'b1110;
            end
            DIG1: begin
                if (tens || !LZ_BLANK) begin
                    glyph  = glyph_t'({3'b000, tens});
                    an_nxt = 4'b1101;
                end
            end
            DIG3: begin
                glyph  = snap_up ? G_U : G_D;
                an_nxt = 4'b0111;
            end
            default: begin
                glyph  = G_BLANK;
                an_nxt = AN_OFF;
            end
        endcase
        if (!bus.enable || tick < BLANK_T) begin
            glyph  = G_BLANK;
            an_nxt = AN_OFF;
        end
    end

    seg7_encode u_encode (
        .glyph (glyph),
        .seg   (seg_nxt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.an  <= AN_OFF;
            bus.seg <= SEG_BLANK;
        end else begin
            bus.an  <= an_nxt;
            bus.seg <= seg_nxt;
        end
    end

    assign bus.dp = 1'b1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Random and directed scan stimulus against a per-cycle reference of the display rules.
module tb_seg7_scan_driver;

    localparam int T     = 8;
    localparam int B     = 2;
    localparam int FRAME = 4 * T;

    localparam logic [6:0] DIGIT_PAT [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
    localparam logic [6:0] PAT_U = 7'b1000001;
    localparam logic [6:0] PAT_D = 7'b0100001;
    localparam logic [6:0] OFF7  = 7'b1111111;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } out_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seg7_scan_driver_if bus ();

    seg7_scan_driver #(
        .DIGIT_TICKS (T),
        .BLANK_TICKS (B),
        .LZ_BLANK    (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         total = 0;
    int         bad   = 0;
    out_t       expq[$];
    logic [4:0] hist[$];
    int         e;
    logic [3:0] m_val;
    logic       m_up;
    logic       m_first;

    // Input as seen just before clock edge k (edges counted from reset release).
    function automatic logic [4:0] x_at(int k);
        if (k >= 1 && k <= hist.size()) return hist[k-1];
        return 5'b0;
    endfunction

    function automatic out_t expect_out(int tick, int slot, logic [3:0] v, logic up, logic en);
        out_t o;
        int   tn, un;
        o.an  = 4'b1111;
        o.seg = OFF7;
        o.dp  = 1'b1;
        tn = int'(v) / 10;
        un = int'(v) % 10;
        if (en && tick >= B) begin
            case (slot)
                0: begin o.an = 4'b1110; o.seg = DIGIT_PAT[un]; end
                1: if (tn != 0) begin o.an = 4'b1101; o.seg = DIGIT_PAT[tn]; end
                3: begin o.an = 4'b0111; o.seg = up ? PAT_U : PAT_D; end
                default: ;
            endcase
        end
        return o;
    endfunction

    // Reference: position in the scan is pure arithmetic on the edge count; the
    // snapshot follows the "settled input, first cycle or frame start" rule.
    always @(posedge clk) begin
        if (!reset) begin
            logic [4:0] a, b;
            e = e + 1;
            hist.push_back({bus.value_in, bus.count_up});
            expq.push_back(expect_out((e - 1) % T, ((e - 1) / T) % 4, m_val, m_up, bus.enable));
            a = x_at(e - 2);
            b = x_at(e - 3);
            if (a == b && (m_first || (e % T == 0 && (e / T) % 4 == 0))) begin
                m_val   = a[4:1];
                m_up    = a[0];
                m_first = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            total++;
            if (bus.an !== 4'b1111 || bus.seg !== OFF7 || bus.dp !== 1'b1) begin
                bad++;
                $display("FAIL reset_hold: got an=%b seg=%b dp=%b, want an=1111 seg=1111111 dp=1",
                         bus.an, bus.seg, bus.dp);
            end
        end else if (expq.size() > 0) begin
            out_t want, got;
            want = expq.pop_front();
            got  = {bus.an, bus.seg, bus.dp};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL scan e=%0d: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                         e, got.an, got.seg, got.dp, want.an, want.seg, want.dp);
            end
        end
    end

    task automatic apply_reset();
        reset   = 1'b1;
        expq.delete();
        hist.delete();
        e       = 0;
        m_val   = 4'd0;
        m_up    = 1'b1;
        m_first = 1'b1;
    endtask

    task automatic run(int n);
        repeat (n) @(negedge clk);
    endtask

    // Park at the negedge where the scan state is (slot, tick) = p.
    task automatic wait_pos(int p);
        int k;
        for (k = 0; k < 2 * FRAME; k++) begin
            @(negedge clk);
            if (e % FRAME == p) break;
        end
        if (k == 2 * FRAME) begin
            total++;
            bad++;
            $display("FAIL wait_pos: position %0d not reached, got e=%0d", p, e);
        end
    endtask

    task automatic async_reset_dig3();
        bus.enable = 1'b1;
        run(FRAME);
        wait_pos(3 * T + 5);
        #1 apply_reset();
        #1;
        total++;
        if (bus.an !== 4'b1111 || bus.seg !== OFF7 || bus.dp !== 1'b1) begin
            bad++;
            $display("FAIL async_reset: got an=%b seg=%b dp=%b, want an=1111 seg=1111111 dp=1",
                     bus.an, bus.seg, bus.dp);
        end
        run(2);
        reset = 1'b0;
    endtask

    initial begin
        bus.value_in = 4'd7;
        bus.count_up = 1'b1;
        bus.enable   = 1'b1;
        apply_reset();
        run(3);
        reset = 1'b0;
        run(3 * FRAME);

        bus.value_in = 4'd12;
        run(2 * FRAME);
        bus.value_in = 4'd0;
        run(2 * FRAME);
        bus.value_in = 4'd15;
        run(2 * FRAME);

        bus.value_in = 4'd3;
        run(2 * FRAME);
        wait_pos(T + 3);
        bus.value_in = 4'd4;
        run(2 * FRAME);

        bus.count_up = 1'b0;
        run(2 * FRAME);
        wait_pos(0);
        bus.enable = 1'b0;
        run(FRAME);
        bus.enable = 1'b1;
        run(FRAME);

        async_reset_dig3();
        run(2 * FRAME);

        for (int i = 0; i < 60; i++) begin
            bus.value_in = 4'($urandom_range(0, 15));
            bus.count_up = 1'($urandom_range(0, 1));
            bus.enable   = ($urandom_range(0, 7) != 0);
            run($urandom_range(1, 3 * FRAME));
            if (i == 30) async_reset_dig3();
        end

        run(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
